// File: rtl/lwe_uniform_sampler.sv
// Rejection sampler: pulls 256-bit PRNG words, slices them into COEFF_W-bit
// candidates and streams N coefficients uniform in [0, Q-1] downstream.
module lwe_uniform_sampler #(
    parameter int WORD_W  = 256,
    parameter int COEFF_W = 12,
    parameter int Q       = 3329,
    parameter int N       = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  rand_valid,
    output logic                                  rand_ready,
    input  logic [WORD_W-1:0]                     rand_word,
    output logic                                  coeff_valid,
    input  logic                                  coeff_ready,
    output logic [COEFF_W-1:0]                    coeff_data,
    output logic [$clog2(N)-1:0]                  coeff_idx,
    output logic [15:0]                           reject_cnt,
    output logic [1:0]                            dbg_state,
    output logic [$clog2(WORD_W/COEFF_W)-1:0]     dbg_chunk_ptr
);

    localparam int CHUNKS = WORD_W / COEFF_W;
    localparam int BUF_W  = CHUNKS * COEFF_W;
    localparam int PTR_W  = $clog2(CHUNKS);
    localparam int IDX_W  = $clog2(N);
    localparam logic [COEFF_W:0] Q_EXT = (COEFF_W + 1)'(Q);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [PTR_W-1:0]   chunk_ptr_q, chunk_ptr_d;
    logic [IDX_W-1:0]   coeff_idx_q, coeff_idx_d;
    logic [15:0]        reject_cnt_q, reject_cnt_d;

    logic [COEFF_W-1:0] cand;
    logic               cand_ok;
    logic               last_chunk;
    logic               last_coeff;
    logic [PTR_W-1:0]   ptr_next;

    // The discarded top bits of each word never reach the buffer.
    generate
        if (WORD_W > BUF_W) begin : g_unused_top
            logic unused_top;
            assign unused_top = ^rand_word[WORD_W-1:BUF_W];
        end
    endgenerate

    always_comb begin
        cand = buf_q[COEFF_W-1:0];
        for (int i = 0; i < CHUNKS; i++) begin
            if (chunk_ptr_q == PTR_W'(i)) begin
                cand = buf_q[i*COEFF_W +: COEFF_W];
            end
        end
    end

    assign cand_ok    = ({1'b0, cand} < Q_EXT);
    assign last_chunk = (chunk_ptr_q == PTR_W'(CHUNKS - 1));
    assign last_coeff = (coeff_idx_q == IDX_W'(N - 1));
    assign ptr_next   = last_chunk ? '0 : chunk_ptr_q + 1'b1;

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign rand_ready    = (state_q == FETCH);
    assign coeff_valid   = (state_q == SAMPLE) && cand_ok;
    assign coeff_data    = (state_q == SAMPLE) ? cand : '0;
    assign coeff_idx     = coeff_idx_q;
    assign reject_cnt    = reject_cnt_q;
    assign dbg_state     = state_q;
    assign dbg_chunk_ptr = chunk_ptr_q;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        chunk_ptr_d  = chunk_ptr_q;
        coeff_idx_d  = coeff_idx_q;
        reject_cnt_d = reject_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = FETCH;
                    coeff_idx_d  = '0;
                    reject_cnt_d = '0;
                end
            end
            FETCH: begin
                if (rand_valid) begin
                    buf_d       = rand_word[BUF_W-1:0];
                    chunk_ptr_d = '0;
                    state_d     = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!cand_ok) begin
                    chunk_ptr_d = ptr_next;
                    if (reject_cnt_q != 16'hFFFF) begin
                        reject_cnt_d = reject_cnt_q + 16'd1;
                    end
                    if (last_chunk) begin
                        state_d = FETCH;
                    end
                end else if (coeff_ready) begin
                    // Completing the polynomial wins over refilling the buffer.
                    chunk_ptr_d = ptr_next;
                    coeff_idx_d = coeff_idx_q + 1'b1;
                    if (last_coeff) begin
                        state_d = DONE;
                    end else if (last_chunk) begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            chunk_ptr_q  <= '0;
            coeff_idx_q  <= '0;
            reject_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            chunk_ptr_q  <= chunk_ptr_d;
            coeff_idx_q  <= coeff_idx_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

endmodule

// File: tb/tb_lwe_uniform_sampler.sv
// Bench for lwe_uniform_sampler: vector table of single-word polynomials,
// hand-written multi-cycle sequences, and a scoreboard of expected coefficients.
module tb_lwe_uniform_sampler;

    localparam int WORD_W  = 256;
    localparam int COEFF_W = 12;
    localparam int Q       = 3329;
    localparam int N       = 256;
    localparam int CHUNKS  = 21;
    localparam int IDX_W   = 8;
    localparam int PTR_W   = 5;
    localparam int S_IDLE   = 0;
    localparam int S_SAMPLE = 2;

    logic                clk;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                rand_valid;
    logic                rand_ready;
    logic [WORD_W-1:0]   rand_word;
    logic                coeff_valid;
    logic                coeff_ready;
    logic [COEFF_W-1:0]  coeff_data;
    logic [IDX_W-1:0]    coeff_idx;
    logic [15:0]         reject_cnt;
    logic [1:0]          dbg_state;
    logic [PTR_W-1:0]    dbg_chunk_ptr;

    lwe_uniform_sampler #(
        .WORD_W (WORD_W),
        .COEFF_W(COEFF_W),
        .Q      (Q),
        .N      (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rand_valid   (rand_valid),
        .rand_ready   (rand_ready),
        .rand_word    (rand_word),
        .coeff_valid  (coeff_valid),
        .coeff_ready  (coeff_ready),
        .coeff_data   (coeff_data),
        .coeff_idx    (coeff_idx),
        .reject_cnt   (reject_cnt),
        .dbg_state    (dbg_state),
        .dbg_chunk_ptr(dbg_chunk_ptr)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    // ---------------- counters and scoreboard ----------------
    int checks    = 0;
    int errors    = 0;
    int rand_hs   = 0;
    int coeff_hs  = 0;
    int done_cnt  = 0;
    int model_idx = 0;
    int model_rej = 0;
    logic [IDX_W+COEFF_W-1:0] exp_q[$];

    typedef struct {
        logic [WORD_W-1:0] word;
        int                acc;
        int                rej;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] make_word(input logic [11:0] c0, input logic [11:0] c1,
                                                    input logic [11:0] c2, input logic [11:0] c3,
                                                    input logic [11:0] fill);
        logic [WORD_W-1:0] w;
        w = '1;
        for (int i = 0; i < CHUNKS; i++) begin
            case (i)
                0:       w[i*COEFF_W +: COEFF_W] = c0;
                1:       w[i*COEFF_W +: COEFF_W] = c1;
                2:       w[i*COEFF_W +: COEFF_W] = c2;
                3:       w[i*COEFF_W +: COEFF_W] = c3;
                default: w[i*COEFF_W +: COEFF_W] = fill;
            endcase
        end
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    // Reference rejection sampler: expected coefficients of one consumed word.
    function automatic void model_word(input logic [WORD_W-1:0] w);
        logic [COEFF_W-1:0] c;
        for (int i = 0; i < CHUNKS; i++) begin
            if (model_idx == N) break;
            c = w[i*COEFF_W +: COEFF_W];
            if (int'(c) < Q) begin
                exp_q.push_back({IDX_W'(model_idx), c});
                model_idx++;
            end else begin
                model_rej++;
            end
        end
    endfunction

    // Monitor samples just before each rising edge, when inputs are final.
    logic [IDX_W+COEFF_W-1:0] exp_e;
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (rand_valid && rand_ready) begin
                rand_hs++;
                model_word(rand_word);
            end
            if (coeff_valid && coeff_ready) begin
                coeff_hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL coeff_unexpected: got idx %0d data 0x%0h expected none",
                             coeff_idx, coeff_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("coeff_idx_data", 32'({coeff_idx, coeff_data}), 32'(exp_e));
                end
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_poly();
        model_idx = 0;
        model_rej = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(dbg_state), S_IDLE);
        rst = 1'b0;
        exp_q.delete();
        model_idx = 0;
        model_rej = 0;
    endtask

    // Drive one word until it is consumed; records timeout as a failure.
    task automatic feed_word(input logic [WORD_W-1:0] w, input string name);
        int rh;
        rh = rand_hs;
        rand_word  = w;
        rand_valid = 1'b1;
        for (int k = 0; k < 10 && rand_hs == rh; k++) tick();
        check({name, "_rand_hs"}, 32'(rand_hs - rh), 1);
        rand_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ch, rh, dc, k, prev_ch;
        logic seen;

        vecs[0] = '{make_word(12'h005, 12'hD01, 12'hD00, 12'hFFF, 12'h000), 19, 2};
        vecs[1] = '{{WORD_W{1'b1}}, 0, 21};
        vecs[2] = '{make_word(12'h001, 12'h001, 12'h001, 12'h001, 12'h001), 21, 0};
        vecs[3] = '{make_word(12'hD00, 12'hD01, 12'hD02, 12'hFFF, 12'hFFF), 1, 20};
        vecs[4] = '{make_word(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hC00), 17, 4};

        rst = 1'b1; start = 1'b0; rand_valid = 1'b1; rand_word = '1; coeff_ready = 1'b1;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_rand_ready", 32'(rand_ready), 0);
        check("reset_coeff_valid", 32'(coeff_valid), 0);
        check("reset_coeff_data", 32'(coeff_data), 0);
        check("reset_coeff_idx", 32'(coeff_idx), 0);
        check("reset_reject_cnt", 32'(reject_cnt), 0);
        check("reset_state", 32'(dbg_state), S_IDLE);
        check("reset_chunk_ptr", 32'(dbg_chunk_ptr), 0);
        rst = 1'b0;
        rand_valid = 1'b0;
        tick();

        // Table: one word per polynomial, then abandon with reset.
        for (int v = 0; v < 5; v++) begin
            start_poly();
            check("vec_fetch_ready", 32'(rand_ready), 1);
            coeff_ready = 1'b1;
            ch = coeff_hs;
            feed_word(vecs[v].word, "vec");
            k = 0;
            while (!rand_ready && k < 40) begin
                tick();
                k++;
            end
            check("vec_sample_cycles", 32'(k), CHUNKS);
            check("vec_reject_cnt", 32'(reject_cnt), 32'(vecs[v].rej));
            check("vec_accepted", 32'(coeff_hs - ch), 32'(vecs[v].acc));
            check("vec_queue_empty", 32'(exp_q.size()), 0);
            reset_dut();
        end

        // Backpressure: coefficient held stable while ready is low.
        start_poly();
        coeff_ready = 1'b0;
        feed_word(make_word(12'h123, 12'h001, 12'h001, 12'h001, 12'h001), "bp");
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(coeff_valid), 1);
            check("bp_data", 32'(coeff_data), 32'h123);
            check("bp_idx", 32'(coeff_idx), 0);
            check("bp_ptr", 32'(dbg_chunk_ptr), 0);
            tick();
        end
        ch = coeff_hs;
        coeff_ready = 1'b1;
        tick();
        coeff_ready = 1'b0;
        check("bp_one_hs", 32'(coeff_hs - ch), 1);
        check("bp_idx_after", 32'(coeff_idx), 1);
        check("bp_data_after", 32'(coeff_data), 32'h001);
        check("bp_ptr_after", 32'(dbg_chunk_ptr), 1);
        tick();
        check("bp_no_extra_hs", 32'(coeff_hs - ch), 1);
        reset_dut();

        // Full polynomial with rand_valid held high.
        start_poly();
        rand_word = make_word(12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
        rand_valid = 1'b1;
        coeff_ready = 1'b1;
        rh = rand_hs; ch = coeff_hs; dc = done_cnt;
        seen = 1'b0; prev_ch = 0;
        for (int i = 0; i < 400; i++) begin
            prev_ch = coeff_hs - ch;
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("full_done_seen", 32'(seen), 1);
        check("full_rand_hs", 32'(rand_hs - rh), 13);
        check("full_coeff_hs", 32'(coeff_hs - ch), N);
        check("full_hs_before_done", 32'(prev_ch), N - 1);
        check("full_busy_at_done", 32'(busy), 1);
        tick();
        check("full_done_pulse", 32'(done), 0);
        check("full_busy_fall", 32'(busy), 0);
        check("full_idle_no_fetch", 32'(rand_ready), 0);
        check("full_done_count", 32'(done_cnt - dc), 1);
        check("full_queue_empty", 32'(exp_q.size()), 0);

        // Random words with random backpressure, then an immediate restart.
        start_poly();
        coeff_ready = 1'b1;
        feed_word('1, "seq");
        rand_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rand_word   = rnd_word();
            coeff_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("seq_done_seen", 32'(seen), 1);
        check("seq_reject_cnt", 32'(reject_cnt), 32'(model_rej));
        check("seq_queue_empty", 32'(exp_q.size()), 0);
        tick();
        start_poly();
        check("seq_rej_clear", 32'(reject_cnt), 0);
        check("seq_idx_clear", 32'(coeff_idx), 0);
        check("seq_fetch", 32'(rand_ready), 1);
        check("seq_no_valid", 32'(coeff_valid), 0);
        rand_word   = make_word(12'h001, 12'h001, 12'h001, 12'h001, 12'h001);
        coeff_ready = 1'b1;
        rh = rand_hs;
        for (int i = 0; i < 10 && !coeff_valid; i++) tick();
        check("seq_first_valid", 32'(coeff_valid), 1);
        check("seq_fetch_before_coeff", 32'(rand_hs - rh), 1);
        check("seq_first_idx", 32'(coeff_idx), 0);

        // Start while busy is ignored; reset mid-polynomial abandons it.
        for (int i = 0; i < 20 && !(coeff_valid && coeff_idx == 8'd5); i++) tick();
        check("busy_at_idx5", 32'(coeff_idx), 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_idx", 32'(coeff_idx), 6);
        check("start_ignored_state", 32'(dbg_state), S_SAMPLE);
        check("start_ignored_rej", 32'(reject_cnt), 0);
        for (int i = 0; i < 20 && !(coeff_valid && coeff_idx == 8'd10); i++) tick();
        check("busy_at_idx10", 32'(coeff_idx), 10);
        dc = done_cnt;
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_rand_ready", 32'(rand_ready), 0);
        check("midrst_coeff_valid", 32'(coeff_valid), 0);
        check("midrst_coeff_data", 32'(coeff_data), 0);
        check("midrst_coeff_idx", 32'(coeff_idx), 0);
        check("midrst_reject_cnt", 32'(reject_cnt), 0);
        check("midrst_state", 32'(dbg_state), S_IDLE);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("midrst_no_done", 32'(done_cnt - dc), 0);
        check("midrst_stays_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
